// File: rtl/host_csr_pkg.sv
// host_csr_pkg: register map, CTRL bit indices and host FSM state for host_csr_file
package host_csr_pkg;
  localparam logic [7:0] CTRL_ADDR   = 8'h00;
  localparam logic [7:0] CYCLES_ADDR = 8'h04;
  localparam logic [7:0] CONST_ADDR  = 8'h08;
  localparam logic [7:0] LEN_ADDR    = 8'h0C;
  localparam logic [7:0] SRC_LO_ADDR = 8'h10;
  localparam logic [7:0] SRC_HI_ADDR = 8'h14;
  localparam logic [7:0] DST_LO_ADDR = 8'h18;
  localparam logic [7:0] DST_HI_ADDR = 8'h1C;
  localparam int LAUNCH_BIT  = 0;
  localparam int DONE_BIT    = 1;
  localparam int TIMEOUT_BIT = 2;
  typedef enum logic {IDLE, RESP} host_state_e;
  function automatic logic [7:0] arg_addr(input int i);
    return CONST_ADDR + 8'(4 * i);
  endfunction
endpackage

// File: rtl/host_csr_if.sv
// host_csr_if: host MMIO request/response channel between host queue and CSR file
interface host_csr_if #(parameter int ADDR_BITS = 8, parameter int DATA_BITS = 32);
  logic                 host_req_valid;
  logic                 host_req_opcode;
  logic [ADDR_BITS-1:0] host_req_addr;
  logic [DATA_BITS-1:0] host_req_value;
  logic                 host_req_deq;
  logic                 host_resp_valid;
  logic [DATA_BITS-1:0] host_resp_bits;
  modport master (
    output host_req_valid, host_req_opcode, host_req_addr, host_req_value,
    input  host_req_deq, host_resp_valid, host_resp_bits
  );
  modport slave (
    input  host_req_valid, host_req_opcode, host_req_addr, host_req_value,
    output host_req_deq, host_resp_valid, host_resp_bits
  );
endinterface

// File: rtl/host_csr_cycle_counter.sv
// host_csr_cycle_counter: saturating busy-cycle counter with clear/freeze; watchdog compare under HOST_CSR_TIMEOUT_EN
module host_csr_cycle_counter #(
  parameter int W = 32
`ifdef HOST_CSR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] count,
  output logic         hit
);
  logic step;
  assign step = en && !freeze && count != '1;
`ifdef HOST_CSR_TIMEOUT_EN
  assign hit = step && count == W'(TIMEOUT_CYCLES - 1);
`else
  assign hit = 1'b0;
`endif
  // clear wins over counting so a relaunch always restarts at zero
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else count <= clr ? '0 : step ? count + W'(1) : count;
endmodule

// File: rtl/host_csr_file.sv
// host_csr_file: host MMIO CSR file driving engine launch/args and collecting status; watchdog under HOST_CSR_TIMEOUT_EN
module host_csr_file
  import host_csr_pkg::*;
#(
  parameter int HOST_ADDR_BITS = 8,
  parameter int HOST_DATA_BITS = 32,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int NUM_ARGS       = 2
`ifdef HOST_CSR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  host_csr_if.slave                 host,
  output logic                      launch,
  input  logic                      finish,
  output logic                      busy,
  output logic [HOST_DATA_BITS-1:0] arg_const,
  output logic [HOST_DATA_BITS-1:0] arg_len,
  output logic [MEM_ADDR_BITS-1:0]  src_addr,
  output logic [MEM_ADDR_BITS-1:0]  dst_addr
);
  host_state_e state, state_nxt;
  logic [HOST_DATA_BITS-1:0] args [NUM_ARGS];
  logic [HOST_DATA_BITS-1:0] src_lo, src_hi, dst_lo, dst_hi, cycles, rd_data, resp_data;
  logic done, tmo, to_hit, wr, rd, fin, go;
  assign wr  = host.host_req_deq && host.host_req_opcode;
  assign rd  = host.host_req_deq && !host.host_req_opcode;
  assign fin = finish && busy;
  assign go  = wr && host.host_req_addr == HOST_ADDR_BITS'(CTRL_ADDR) && host.host_req_value[LAUNCH_BIT] && (!busy || fin);
  assign arg_const = args[0];
  assign arg_len   = args[1];
  assign src_addr  = MEM_ADDR_BITS'({src_hi, src_lo});
  assign dst_addr  = MEM_ADDR_BITS'({dst_hi, dst_lo});
  assign host.host_resp_bits = resp_data;
  host_csr_cycle_counter #(
    .W(HOST_DATA_BITS)
`ifdef HOST_CSR_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_cnt (
    .clock(clock), .reset(reset), .clr(go), .en(busy), .freeze(fin), .count(cycles), .hit(to_hit)
  );
  // host FSM state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // a dequeued read spends one cycle in RESP, writes never leave IDLE
  always_comb state_nxt = (state == IDLE && host.host_req_valid && !host.host_req_opcode) ? RESP : IDLE;
  // deq only from IDLE, response valid only in RESP
  always_comb begin
    host.host_req_deq    = state == IDLE && host.host_req_valid;
    host.host_resp_valid = state == RESP;
  end
  // read mux over the pre-update register values
  always_comb begin
    rd_data = '0;
    case (host.host_req_addr)
      CTRL_ADDR: begin
        rd_data[DONE_BIT]    = done;
        rd_data[TIMEOUT_BIT] = tmo;
      end
      CYCLES_ADDR: rd_data = cycles;
      SRC_LO_ADDR: rd_data = src_lo;
      SRC_HI_ADDR: rd_data = src_hi;
      DST_LO_ADDR: rd_data = dst_lo;
      DST_HI_ADDR: rd_data = dst_hi;
      default: ;
    endcase
    for (int i = 0; i < NUM_ARGS; i++)
      if (host.host_req_addr == HOST_ADDR_BITS'(arg_addr(i))) rd_data = args[i];
  end
  // engine control: finish is applied before a same-cycle launch, so go overrides it
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      launch <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      launch <= go;
      busy   <= go || (busy && !fin && !to_hit);
      done   <= !go && (done || fin);
      tmo    <= !go && (tmo || to_hit);
    end
  // argument/pointer registers and captured read data
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_ARGS; i++) args[i] <= '0;
      src_lo    <= '0;
      src_hi    <= '0;
      dst_lo    <= '0;
      dst_hi    <= '0;
      resp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_ARGS; i++)
        if (wr && host.host_req_addr == HOST_ADDR_BITS'(arg_addr(i))) args[i] <= host.host_req_value;
      if (wr && host.host_req_addr == HOST_ADDR_BITS'(SRC_LO_ADDR)) src_lo <= host.host_req_value;
      if (wr && host.host_req_addr == HOST_ADDR_BITS'(SRC_HI_ADDR)) src_hi <= host.host_req_value;
      if (wr && host.host_req_addr == HOST_ADDR_BITS'(DST_LO_ADDR)) dst_lo <= host.host_req_value;
      if (wr && host.host_req_addr == HOST_ADDR_BITS'(DST_HI_ADDR)) dst_hi <= host.host_req_value;
      if (rd) resp_data <= rd_data;
    end
endmodule

// File: tb/tb_host_csr_file.sv
// tb_host_csr_file: directed self-checking bench for host_csr_file
module tb_host_csr_file;
  import host_csr_pkg::*;
  logic clock = 1'b0, reset = 1'b0, finish = 1'b0;
  logic launch, busy;
  logic [31:0] arg_const, arg_len;
  logic [63:0] src_addr, dst_addr;
  int checks = 0, errors = 0, launch_cnt = 0;
  host_csr_if #(.ADDR_BITS(8), .DATA_BITS(32)) h ();
`ifdef HOST_CSR_TIMEOUT_EN
  host_csr_file #(.HOST_ADDR_BITS(8), .HOST_DATA_BITS(32), .MEM_ADDR_BITS(64), .NUM_ARGS(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .host(h), .launch(launch), .finish(finish), .busy(busy),
    .arg_const(arg_const), .arg_len(arg_len), .src_addr(src_addr), .dst_addr(dst_addr)
  );
`else
  host_csr_file #(.HOST_ADDR_BITS(8), .HOST_DATA_BITS(32), .MEM_ADDR_BITS(64), .NUM_ARGS(2)) dut (
    .clock(clock), .reset(reset), .host(h), .launch(launch), .finish(finish), .busy(busy),
    .arg_const(arg_const), .arg_len(arg_len), .src_addr(src_addr), .dst_addr(dst_addr)
  );
`endif
  always #5 clock = ~clock;
  always @(posedge clock) if (launch) launch_cnt++;

  task automatic write_reg(input logic [7:0] a, input logic [31:0] v);
    @(negedge clock);
    h.host_req_valid = 1'b1; h.host_req_opcode = 1'b1; h.host_req_addr = a; h.host_req_value = v;
    @(negedge clock);
    h.host_req_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d, output logic ok);
    logic dq;
    @(negedge clock);
    h.host_req_valid = 1'b1; h.host_req_opcode = 1'b0; h.host_req_addr = a; h.host_req_value = '0;
    #1 dq = h.host_req_deq;
    @(negedge clock);
    ok = dq && h.host_resp_valid && !h.host_req_deq;
    d = h.host_resp_bits;
    h.host_req_valid = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clock); finish = 1'b1;
    @(negedge clock); finish = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ok;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %b want 0", launch); end
    checks++; if (h.host_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", h.host_resp_valid); end
    checks++; if (h.host_resp_bits !== 32'h0) begin errors++; $display("FAIL reset_resp_bits got %h want 0", h.host_resp_bits); end
    checks++; if (src_addr !== 64'h0 || arg_const !== 32'h0) begin errors++; $display("FAIL reset_args got %h/%h want 0", src_addr, arg_const); end
    reset = 1'b1;
    read_reg(CONST_ADDR, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL reset_rd_const got %h ok=%b want 0 ok=1", d, ok); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL reset_rd_cycles got %h ok=%b want 0 ok=1", d, ok); end
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL reset_rd_ctrl got %h ok=%b want 0 ok=1", d, ok); end
    @(negedge clock);
    checks++; if (h.host_resp_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle got %b want 0", h.host_resp_valid); end
  endtask

  task automatic test_args();
    logic [31:0] d; logic ok;
    write_reg(CONST_ADDR, 32'h2);
    write_reg(LEN_ADDR, 32'h40);
    write_reg(SRC_LO_ADDR, 32'h1000);
    write_reg(SRC_HI_ADDR, 32'h1);
    write_reg(DST_LO_ADDR, 32'h2000);
    write_reg(DST_HI_ADDR, 32'h3);
    checks++; if (arg_const !== 32'd2) begin errors++; $display("FAIL arg_const got %h want 2", arg_const); end
    checks++; if (arg_len !== 32'd64) begin errors++; $display("FAIL arg_len got %h want 40", arg_len); end
    checks++; if (src_addr !== 64'h0000_0001_0000_1000) begin errors++; $display("FAIL src_addr got %h want 0000000100001000", src_addr); end
    checks++; if (dst_addr !== 64'h0000_0003_0000_2000) begin errors++; $display("FAIL dst_addr got %h want 0000000300002000", dst_addr); end
    read_reg(LEN_ADDR, d, ok);
    checks++; if (d !== 32'h40 || !ok) begin errors++; $display("FAIL rd_len got %h ok=%b want 40", d, ok); end
    read_reg(SRC_HI_ADDR, d, ok);
    checks++; if (d !== 32'h1 || !ok) begin errors++; $display("FAIL rd_src_hi got %h ok=%b want 1", d, ok); end
    write_reg(8'h20, 32'hDEAD_BEEF);
    read_reg(8'h20, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL rd_unmapped got %h ok=%b want 0", d, ok); end
    checks++; if (arg_const !== 32'd2 || dst_addr !== 64'h0000_0003_0000_2000) begin errors++; $display("FAIL unmapped_write_dropped got %h/%h", arg_const, dst_addr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [4] = '{CONST_ADDR, LEN_ADDR, DST_LO_ADDR, DST_HI_ADDR};
    logic [31:0] vals  [4] = '{32'd5, 32'd6, 32'd7, 32'd8};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      h.host_req_valid = 1'b1; h.host_req_opcode = 1'b1; h.host_req_addr = addrs[i]; h.host_req_value = vals[i];
      #1;
      checks++; if (h.host_req_deq !== 1'b1) begin errors++; $display("FAIL b2b_deq[%0d] got %b want 1", i, h.host_req_deq); end
    end
    @(negedge clock);
    h.host_req_valid = 1'b0;
    checks++; if (arg_const !== 32'd5 || arg_len !== 32'd6) begin errors++; $display("FAIL b2b_args got %h/%h want 5/6", arg_const, arg_len); end
    checks++; if (dst_addr !== 64'h0000_0008_0000_0007) begin errors++; $display("FAIL b2b_dst got %h want 0000000800000007", dst_addr); end
  endtask

  task automatic test_launch();
    logic [31:0] d; logic ok; int b = 0;
    launch_cnt = 0;
    write_reg(CTRL_ADDR, 32'h1);
    checks++; if (launch !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL launch_pulse got launch=%b busy=%b want 1/1", launch, busy); end
    for (int i = 0; i < 10; i++) begin
      b += int'(busy);
      @(negedge clock);
    end
    finish = 1'b1;
    @(negedge clock);
    finish = 1'b0;
    checks++; if (b !== 10) begin errors++; $display("FAIL busy_cycles got %0d want 10", b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_finish got %b want 0", busy); end
    checks++; if (launch_cnt !== 1) begin errors++; $display("FAIL launch_count got %0d want 1", launch_cnt); end
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h2 || !ok) begin errors++; $display("FAIL ctrl_done got %h want 2", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd10 || !ok) begin errors++; $display("FAIL cycles_count got %0d want 10", d); end
  endtask

  task automatic test_busy_relaunch();
    logic [31:0] d; logic ok;
    launch_cnt = 0;
    write_reg(CTRL_ADDR, 32'h1);
    write_reg(CTRL_ADDR, 32'h1);
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd3 || !ok) begin errors++; $display("FAIL busy_cycles_a got %0d want 3", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd5 || !ok) begin errors++; $display("FAIL busy_cycles_b got %0d want 5", d); end
    checks++; if (launch_cnt !== 1 || busy !== 1'b1) begin errors++; $display("FAIL relaunch_ignored got cnt=%0d busy=%b want 1/1", launch_cnt, busy); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d; logic ok;
    launch_cnt = 0;
    @(negedge clock);
    h.host_req_valid = 1'b1; h.host_req_opcode = 1'b1; h.host_req_addr = CTRL_ADDR; h.host_req_value = 32'h1;
    finish = 1'b1;
    @(negedge clock);
    h.host_req_valid = 1'b0; finish = 1'b0;
    checks++; if (launch !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sim_launch got launch=%b busy=%b want 1/1", launch, busy); end
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL sim_ctrl got %h want 0", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd3 || !ok) begin errors++; $display("FAIL sim_cycles got %0d want 3", d); end
    checks++; if (launch_cnt !== 1) begin errors++; $display("FAIL sim_launch_count got %0d want 1", launch_cnt); end
    pulse_finish();
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h2 || !ok) begin errors++; $display("FAIL sim_done got %h want 2", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd5 || !ok) begin errors++; $display("FAIL sim_frozen got %0d want 5", d); end
  endtask

  task automatic test_idle_ignores();
    logic [31:0] d; logic ok;
    launch_cnt = 0;
    write_reg(CTRL_ADDR, 32'h0);
    pulse_finish();
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h2 || !ok) begin errors++; $display("FAIL done_sticky got %h want 2", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd5 || !ok) begin errors++; $display("FAIL idle_cycles got %0d want 5", d); end
    checks++; if (busy !== 1'b0 || launch_cnt !== 0) begin errors++; $display("FAIL idle_finish got busy=%b cnt=%0d want 0/0", busy, launch_cnt); end
  endtask

`ifdef HOST_CSR_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d; logic ok; int b = 0;
    write_reg(CTRL_ADDR, 32'h1);
    while (busy && b < 100) begin
      b++;
      @(negedge clock);
    end
    checks++; if (b !== 16) begin errors++; $display("FAIL timeout_busy got %0d want 16", b); end
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h4 || !ok) begin errors++; $display("FAIL timeout_ctrl got %h want 4", d); end
    read_reg(CYCLES_ADDR, d, ok);
    checks++; if (d !== 32'd16 || !ok) begin errors++; $display("FAIL timeout_cycles got %0d want 16", d); end
    pulse_finish();
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h4 || !ok) begin errors++; $display("FAIL late_finish got %h want 4", d); end
    write_reg(CTRL_ADDR, 32'h1);
    read_reg(CTRL_ADDR, d, ok);
    checks++; if (d !== 32'h0 || !ok) begin errors++; $display("FAIL timeout_clear got %h want 0", d); end
    pulse_finish();
  endtask
`endif

  initial begin
    h.host_req_valid = 1'b0; h.host_req_opcode = 1'b0; h.host_req_addr = '0; h.host_req_value = '0;
    test_reset();
    test_args();
    test_back_to_back();
    test_launch();
    test_busy_relaunch();
    test_simultaneous();
    test_idle_ignores();
`ifdef HOST_CSR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
